// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream bundle between the requesters, the arbiter and the uart_transmitter.
// slave is the arbiter side; master is the requester/transmitter side.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_valid;
    logic [7:0]           tx_data;
    logic                 tx_ready;

    modport slave (
        input  req_valid, req_data, req_last, tx_ready,
        output req_ready, tx_valid, tx_data
    );

    modport master (
        output req_valid, req_data, req_last, tx_ready,
        input  req_ready, tx_valid, tx_data
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locked arbiter sharing one uart_transmitter byte port.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | no owner; pick next requester from rr_ptr onward
//   ST_OWN   | owner_idx holds the transmitter; bytes pass straight through
//
// An owner is released on its last byte, on reaching MAX_LEN bytes, or after
// IDLE_TIMEOUT cycles of req_valid low. Every release passes through ST_IDLE
// for one cycle, which is what enforces the round-robin fairness.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int MAX_LEN      = 64,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    uart_tx_arbiter_if.slave   bus,
    output logic [NUM_REQ-1:0] grant,
    output logic               busy,
    output logic               timeout_pulse
);
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int IDLE_W = (IDLE_TIMEOUT > 2) ? $clog2(IDLE_TIMEOUT) : 1;

    localparam logic [IDX_W:0]    NUM_REQ_W  = (IDX_W + 1)'(NUM_REQ);
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_REQ - 1);
    localparam logic [7:0]        LEN_LIMIT  = 8'(MAX_LEN);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(IDLE_TIMEOUT - 1);

    typedef enum logic {ST_IDLE, ST_OWN} state_t;

    state_t            state;
    logic [IDX_W-1:0]  owner_idx;
    logic [IDX_W-1:0]  rr_ptr;
    logic [7:0]        byte_cnt;
    logic [IDLE_W-1:0] idle_cnt;

    logic              own_valid;
    logic              own_last;
    logic [7:0]        own_data;
    logic              xfer;
    logic [7:0]        byte_cnt_nxt;
    logic [IDX_W-1:0]  rr_next;

    logic              pick_found;
    logic [IDX_W-1:0]  pick_idx;
    logic [IDX_W:0]    pick_sum;
    logic [IDX_W-1:0]  cand_idx;

    // Select the current owner's request lines.
    always_comb begin
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_data  = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_idx == IDX_W'(i)) begin
                own_valid = bus.req_valid[i];
                own_last  = bus.req_last[i];
                own_data  = bus.req_data[8*i +: 8];
            end
        end
    end

    assign xfer         = (state == ST_OWN) && own_valid && bus.tx_ready;
    assign byte_cnt_nxt = byte_cnt + 8'd1;
    assign rr_next      = (owner_idx == LAST_IDX) ? '0 : owner_idx + 1'b1;

    // Passthrough to the transmitter; forced quiet while reset is asserted.
    always_comb begin
        bus.tx_valid  = 1'b0;
        bus.tx_data   = 8'h00;
        bus.req_ready = '0;
        if (rst_n && state == ST_OWN) begin
            bus.tx_valid  = own_valid;
            bus.tx_data   = own_valid ? own_data : 8'h00;
            bus.req_ready = grant & {NUM_REQ{bus.tx_ready}};
        end
    end

    // First valid requester at or after rr_ptr; descending loop lets the nearest win.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        pick_sum   = '0;
        cand_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pick_sum = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
            cand_idx = (pick_sum >= NUM_REQ_W) ? IDX_W'(pick_sum - NUM_REQ_W)
                                               : pick_sum[IDX_W-1:0];
            if (bus.req_valid[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    // Arbitration FSM with registered grant, busy and timeout_pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            owner_idx     <= '0;
            rr_ptr        <= '0;
            byte_cnt      <= '0;
            idle_cnt      <= '0;
            grant         <= '0;
            busy          <= 1'b0;
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        state     <= ST_OWN;
                        owner_idx <= pick_idx;
                        grant     <= NUM_REQ'(1) << pick_idx;
                        busy      <= 1'b1;
                        byte_cnt  <= '0;
                        idle_cnt  <= '0;
                    end
                end
                ST_OWN: begin
                    if (xfer) begin
                        byte_cnt <= byte_cnt_nxt;
                        idle_cnt <= '0;
                        // Last flag wins over the cap; both give a plain release.
                        if (own_last || byte_cnt_nxt == LEN_LIMIT) begin
                            state  <= ST_IDLE;
                            grant  <= '0;
                            busy   <= 1'b0;
                            rr_ptr <= rr_next;
                        end
                    end else if (!own_valid) begin
                        if (idle_cnt == IDLE_LIMIT) begin
                            state         <= ST_IDLE;
                            grant         <= '0;
                            busy          <= 1'b0;
                            rr_ptr        <= rr_next;
                            timeout_pulse <= 1'b1;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a main instance (MAX_LEN=64,
// IDLE_TIMEOUT=1024) and a short-cap instance (MAX_LEN=3) share clk/rst_n.
module tb_uart_tx_arbiter;
    localparam int NUM_REQ = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #20 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();
    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus_cap ();

    logic [NUM_REQ-1:0] grant, grant_cap;
    logic               busy, busy_cap;
    logic               timeout_pulse, timeout_cap;

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .MAX_LEN(64), .IDLE_TIMEOUT(1024)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .grant(grant), .busy(busy), .timeout_pulse(timeout_pulse)
    );

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .MAX_LEN(3), .IDLE_TIMEOUT(8)) u_dut_cap (
        .clk(clk), .rst_n(rst_n), .bus(bus_cap),
        .grant(grant_cap), .busy(busy_cap), .timeout_pulse(timeout_cap)
    );

    // Requester byte queues; index 0 feeds u_dut, index 1 feeds u_dut_cap.
    logic [7:0] q_data [2][NUM_REQ][$];
    logic       q_last [2][NUM_REQ][$];
    int         rd_ptr [2][NUM_REQ];
    int         cyc = 0;
    int         ready_div = 1;

    logic [NUM_REQ-1:0] acc, acc_cap;

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] gnt;
        int         cyc;
    } xfer_t;

    typedef struct packed {
        logic [3:0] gnt;
        int         cyc;
    } gchg_t;

    xfer_t xlog[$];
    xfer_t clog[$];
    gchg_t ghist[$];
    logic [3:0] grant_prev = '0;
    logic busy_prev = 1'b0, busy_cap_prev = 1'b0;
    int to_cnt = 0, to_cyc = -1, busy_fall_cyc = -1;
    int cap_rel = 0, cap_to = 0;

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Requester/transmitter driver: retire accepted bytes, present queue heads.
    initial begin
        bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0; bus.tx_ready = 1'b0;
        bus_cap.req_valid = '0; bus_cap.req_data = '0; bus_cap.req_last = '0;
        bus_cap.tx_ready = 1'b1;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < NUM_REQ; i++) rd_ptr[b][i] = 0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (acc[i]) rd_ptr[0][i]++;
                if (acc_cap[i]) rd_ptr[1][i]++;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (rd_ptr[0][i] < q_data[0][i].size()) begin
                    bus.req_valid[i]      = 1'b1;
                    bus.req_data[8*i +: 8] = q_data[0][i][rd_ptr[0][i]];
                    bus.req_last[i]       = q_last[0][i][rd_ptr[0][i]];
                end else begin
                    bus.req_valid[i]      = 1'b0;
                    bus.req_data[8*i +: 8] = 8'h00;
                    bus.req_last[i]       = 1'b0;
                end
                if (rd_ptr[1][i] < q_data[1][i].size()) begin
                    bus_cap.req_valid[i]      = 1'b1;
                    bus_cap.req_data[8*i +: 8] = q_data[1][i][rd_ptr[1][i]];
                    bus_cap.req_last[i]       = q_last[1][i][rd_ptr[1][i]];
                end else begin
                    bus_cap.req_valid[i]      = 1'b0;
                    bus_cap.req_data[8*i +: 8] = 8'h00;
                    bus_cap.req_last[i]       = 1'b0;
                end
            end
            bus.tx_ready = (ready_div != 0) && ((cyc % ready_div) == 0);
        end
    end

    // Observe transfers, grant changes and pulses mid-cycle.
    always @(negedge clk) begin
        acc     = bus.req_valid & bus.req_ready;
        acc_cap = bus_cap.req_valid & bus_cap.req_ready;
        if (bus.tx_valid && bus.tx_ready) xlog.push_back('{bus.tx_data, grant, cyc});
        if (bus_cap.tx_valid && bus_cap.tx_ready) clog.push_back('{bus_cap.tx_data, grant_cap, cyc});
        if (grant != grant_prev) ghist.push_back('{grant, cyc});
        grant_prev = grant;
        if (timeout_pulse) begin
            to_cnt++;
            to_cyc = cyc;
        end
        if (busy_prev && !busy) busy_fall_cyc = cyc;
        busy_prev = busy;
        if (busy_cap_prev && !busy_cap) cap_rel++;
        busy_cap_prev = busy_cap;
        if (timeout_cap) cap_to++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push(input int b, input int r, input logic [7:0] d, input logic l);
        q_data[b][r].push_back(d);
        q_last[b][r].push_back(l);
    endtask

    function automatic bit all_empty();
        bit e = 1'b1;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < NUM_REQ; i++)
                if (rd_ptr[b][i] < q_data[b][i].size()) e = 1'b0;
        return e;
    endfunction

    task automatic wait_quiet(input string tag, input int budget);
        int n = 0;
        while ((busy || busy_cap || !all_empty()) && n < budget) begin
            step(1);
            n++;
        end
        check_eq(tag, 32'(n < budget), 32'd1);
        step(2);
    endtask

    initial begin
        #(40 * 20000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base, gbase, tbase, rbase, n, bad;
        logic [7:0] exp2_d [6];
        logic [3:0] exp2_g [6];
        logic [3:0] exp2_h [6];

        // Test 1: "Hi!" from req 0 with tx_ready every 4th cycle.
        rst_n = 1'b0;
        ready_div = 4;
        step(2);
        rst_n = 1'b1;
        step(1);
        base = xlog.size();
        push(0, 0, 8'h48, 1'b0);
        push(0, 0, 8'h69, 1'b0);
        push(0, 0, 8'h21, 1'b1);
        wait_quiet("t1_done", 200);
        check_eq("t1_count", xlog.size() - base, 3);
        check_eq("t1_b0", xlog[base].data, 8'h48);
        check_eq("t1_b1", xlog[base+1].data, 8'h69);
        check_eq("t1_b2", xlog[base+2].data, 8'h21);
        check_eq("t1_gnt", {xlog[base].gnt, xlog[base+1].gnt, xlog[base+2].gnt}, 12'h111);
        check_eq("t1_busy_fall", busy_fall_cyc, xlog[base+2].cyc + 1);

        // rr_ptr is now 1: with req 0 and req 1 both pending, req 1 goes first.
        base = xlog.size();
        push(0, 0, 8'h55, 1'b1);
        push(0, 1, 8'h66, 1'b1);
        wait_quiet("t1_rr_done", 200);
        check_eq("t1_rr_first", {xlog[base].gnt, xlog[base].data}, {4'b0010, 8'h66});
        check_eq("t1_rr_second", {xlog[base+1].gnt, xlog[base+1].data}, {4'b0001, 8'h55});

        // Test 2: three 2-byte messages pending through reset.
        ready_div = 1;
        rst_n = 1'b0;
        push(0, 0, 8'hA0, 1'b0); push(0, 0, 8'hA1, 1'b1);
        push(0, 1, 8'hB0, 1'b0); push(0, 1, 8'hB1, 1'b1);
        push(0, 2, 8'hC0, 1'b0); push(0, 2, 8'hC1, 1'b1);
        step(2);
        check_eq("rst_grant", grant, 4'b0000);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_timeout", timeout_pulse, 1'b0);
        check_eq("rst_tx_valid", bus.tx_valid, 1'b0);
        check_eq("rst_tx_data", bus.tx_data, 8'h00);
        check_eq("rst_req_ready", bus.req_ready, 4'b0000);
        base  = xlog.size();
        gbase = ghist.size();
        rst_n = 1'b1;
        wait_quiet("t2_done", 100);
        exp2_d = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hC0, 8'hC1};
        exp2_g = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100};
        exp2_h = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000};
        check_eq("t2_count", xlog.size() - base, 6);
        bad = 0;
        for (int k = 0; k < 6; k++)
            if (xlog[base+k].data !== exp2_d[k] || xlog[base+k].gnt !== exp2_g[k]) bad++;
        check_eq("t2_order", bad, 0);
        bad = 0;
        for (int k = 0; k < 6; k++)
            if (ghist[gbase+k].gnt !== exp2_h[k]) bad++;
        check_eq("t2_grant_seq", bad, 0);
        check_eq("t2_gap1", ghist[gbase+2].cyc - ghist[gbase+1].cyc, 1);
        check_eq("t2_gap2", ghist[gbase+4].cyc - ghist[gbase+3].cyc, 1);

        // Test 3: req 3 streams 70 bytes with no last; cap at 64 then timeout.
        base  = xlog.size();
        gbase = ghist.size();
        tbase = to_cnt;
        for (int k = 1; k <= 70; k++) push(0, 3, 8'(k), 1'b0);
        wait_quiet("t3_done", 2000);
        check_eq("t3_count", xlog.size() - base, 70);
        bad = 0;
        for (int k = 0; k < 70; k++)
            if (xlog[base+k].data !== 8'(k + 1) || xlog[base+k].gnt !== 4'b1000) bad++;
        check_eq("t3_bytes", bad, 0);
        check_eq("t3_cap_release", {ghist[gbase+1].gnt, ghist[gbase+1].cyc},
                 {4'b0000, xlog[base+63].cyc + 1});
        check_eq("t3_regrant", {ghist[gbase+2].gnt, ghist[gbase+2].cyc},
                 {4'b1000, ghist[gbase+1].cyc + 1});
        check_eq("t3_byte65_cyc", xlog[base+64].cyc, ghist[gbase+2].cyc);
        check_eq("t3_timeout_cnt", to_cnt - tbase, 1);
        check_eq("t3_timeout_cyc", ghist[gbase+3].cyc, xlog[base+69].cyc + 1025);

        // Test 4: req 1 sends one byte then stalls while req 2 waits.
        base  = xlog.size();
        tbase = to_cnt;
        push(0, 1, 8'h31, 1'b0);
        push(0, 2, 8'h42, 1'b1);
        wait_quiet("t4_done", 1500);
        check_eq("t4_first", {xlog[base].gnt, xlog[base].data}, {4'b0010, 8'h31});
        check_eq("t4_pulse_cnt", to_cnt - tbase, 1);
        check_eq("t4_pulse_cyc", to_cyc, xlog[base].cyc + 1025);
        check_eq("t4_next", {xlog[base+1].gnt, xlog[base+1].data}, {4'b0100, 8'h42});
        check_eq("t4_next_cyc", xlog[base+1].cyc, to_cyc + 1);

        // Test 5: one-cycle reset while req 0 holds tx_valid high.
        ready_div = 0;
        push(0, 0, 8'hE0, 1'b0);
        push(0, 0, 8'hE1, 1'b1);
        n = 0;
        while (grant != 4'b0001 && n < 20) begin
            step(1);
            n++;
        end
        check_eq("t5_owner", grant, 4'b0001);
        check_eq("t5_mid_valid", {bus.tx_valid, bus.tx_data}, {1'b1, 8'hE0});
        rst_n = 1'b0;
        push(0, 3, 8'hD3, 1'b1);
        step(1);
        check_eq("t5_rst_tx", {bus.tx_valid, bus.tx_data, bus.req_ready}, 13'h0);
        check_eq("t5_rst_state", {grant, busy, timeout_pulse}, 6'h0);
        base = xlog.size();
        rst_n = 1'b1;
        ready_div = 1;
        wait_quiet("t5_done", 100);
        check_eq("t5_r0a", {xlog[base].gnt, xlog[base].data}, {4'b0001, 8'hE0});
        check_eq("t5_r0b", {xlog[base+1].gnt, xlog[base+1].data}, {4'b0001, 8'hE1});
        check_eq("t5_r3", {xlog[base+2].gnt, xlog[base+2].data}, {4'b1000, 8'hD3});

        // Test 6: last flag and MAX_LEN=3 coincide on the short-cap instance.
        base  = clog.size();
        rbase = cap_rel;
        tbase = cap_to;
        push(1, 0, 8'h11, 1'b0);
        push(1, 0, 8'h22, 1'b0);
        push(1, 0, 8'h33, 1'b1);
        wait_quiet("t6_done", 100);
        check_eq("t6_count", clog.size() - base, 3);
        check_eq("t6_bytes", {clog[base].data, clog[base+1].data, clog[base+2].data}, 24'h112233);
        check_eq("t6_gnt", {clog[base].gnt, clog[base+1].gnt, clog[base+2].gnt}, 12'h111);
        check_eq("t6_releases", cap_rel - rbase, 1);
        check_eq("t6_timeouts", cap_to - tbase, 0);
        base = clog.size();
        push(1, 0, 8'h44, 1'b1);
        push(1, 1, 8'h55, 1'b1);
        wait_quiet("t6_rr_done", 100);
        check_eq("t6_rr_first", {clog[base].gnt, clog[base].data}, {4'b0010, 8'h55});
        check_eq("t6_rr_second", {clog[base+1].gnt, clog[base+1].data}, {4'b0001, 8'h44});

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
